avalon_led_gpio: RTL

- Avalon-MM slave (responder) LED peripheral on the picorv32 SoC interconnect.
- Answers CPU (master) reads and writes to a small register file.
- Drives the CYC1000 LED bank with static and blinking patterns.
- Fixed read latency of 1 (readdatavalid); never stalls the master.

---
 rtl/avalon_led_gpio.sv | 127 ++++++++++++
 1 files changed

// File: rtl/avalon_led_gpio.sv
// Avalon-MM LED peripheral: OUT/SET/CLR/TOG/BMASK/PERIOD/STATUS register file
// with a prescaled blink engine XORed onto the masked LEDs. Read latency is 1.
module avalon_led_gpio #(
  parameter int LED_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 24,
  parameter int PERIOD_RESET = 6000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  input  logic [3:0]           avs_byteenable,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 avs_waitrequest,
  output logic [LED_WIDTH-1:0] led_signal
);

  localparam logic [2:0] A_OUT    = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TOG    = 3'd3;
  localparam logic [2:0] A_BMASK  = 3'd4;
  localparam logic [2:0] A_PERIOD = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [LED_WIDTH-1:0] merge_led(input logic [LED_WIDTH-1:0] old,
                                                     input logic [LED_WIDTH-1:0] wd,
                                                     input logic [LED_WIDTH-1:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  function automatic logic [PERIOD_WIDTH-1:0] merge_per(input logic [PERIOD_WIDTH-1:0] old,
                                                        input logic [PERIOD_WIDTH-1:0] wd,
                                                        input logic [PERIOD_WIDTH-1:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  logic [LED_WIDTH-1:0]    out_q, out_nx, bmask_q, bmask_nx;
  logic [PERIOD_WIDTH-1:0] period_q, period_nx, cnt_q, cnt_nx;
  logic                    phase_q, phase_nx, period_wr;
  logic [31:0]             wmask, rdata_p0, rdata_p1;
  logic [LED_WIDTH-1:0]    m_led, wbits;
  logic                    vld_p1;
  logic                    unused_bits;

  assign avs_waitrequest   = 1'b0;
  assign avs_readdata      = rdata_p1;
  assign avs_readdatavalid = vld_p1;
  assign unused_bits       = ^{avs_writedata, wmask};

  always_comb begin
    wmask     = lane_mask(avs_byteenable);
    m_led     = wmask[LED_WIDTH-1:0];
    wbits     = avs_writedata[LED_WIDTH-1:0] & m_led;
    out_nx    = out_q;
    bmask_nx  = bmask_q;
    period_nx = period_q;
    period_wr = 1'b0;
    if (avs_write) begin
      case (avs_address)
        A_OUT:    out_nx   = merge_led(out_q, avs_writedata[LED_WIDTH-1:0], m_led);
        A_SET:    out_nx   = out_q | wbits;
        A_CLR:    out_nx   = out_q & ~wbits;
        A_TOG:    out_nx   = out_q ^ wbits;
        A_BMASK:  bmask_nx = merge_led(bmask_q, avs_writedata[LED_WIDTH-1:0], m_led);
        A_PERIOD: begin
          period_nx = merge_per(period_q, avs_writedata[PERIOD_WIDTH-1:0],
                                wmask[PERIOD_WIDTH-1:0]);
          period_wr = 1'b1;
        end
        default: ;
      endcase
    end

    // >= compare lets a shrinking period wrap immediately instead of overshooting
    cnt_nx   = cnt_q + PERIOD_WIDTH'(1);
    phase_nx = phase_q;
    if (period_wr) begin
      cnt_nx = '0;
    end else if (period_q == '0) begin
      cnt_nx   = '0;
      phase_nx = 1'b0;
    end else if (cnt_q >= period_q - PERIOD_WIDTH'(1)) begin
      cnt_nx   = '0;
      phase_nx = ~phase_q;
    end

    case (avs_address)
      A_OUT, A_SET, A_CLR, A_TOG: rdata_p0 = 32'(out_q);
      A_BMASK:  rdata_p0 = 32'(bmask_q);
      A_PERIOD: rdata_p0 = 32'(period_q);
      A_STATUS: rdata_p0 = 32'({cnt_q, phase_q});
      default:  rdata_p0 = '0;
    endcase
  end

  // stage p1: register file, blink state, LED drive and read response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      bmask_q    <= '0;
      period_q   <= PERIOD_WIDTH'(PERIOD_RESET);
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      led_signal <= '0;
      rdata_p1   <= '0;
      vld_p1     <= 1'b0;
    end else begin
      out_q      <= out_nx;
      bmask_q    <= bmask_nx;
      period_q   <= period_nx;
      cnt_q      <= cnt_nx;
      phase_q    <= phase_nx;
      led_signal <= out_nx ^ (bmask_nx & {LED_WIDTH{phase_nx}});
      vld_p1     <= avs_read;
      if (avs_read) rdata_p1 <= rdata_p0;
    end
  end

endmodule
